// File: rtl/instr_fetch_queue.sv
// Decoupled instruction fetch front end: sequential address generator, single-outstanding
// instruction-memory handshake and a DEPTH-entry FIFO presenting {pc, pc+4, instr} to IF/ID.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [31:0]            imem_data_i,
  output logic                   instr_valid_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            pc_o,
  output logic [31:0]            pc_plus_four_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     pc_mem_d    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     instr_mem_d [DEPTH];

  logic            valid;
  logic            pop;
  logic            push;
  logic            can_issue;
  logic            req;
  logic [31:0]     addr;

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  assign valid     = rst_i & (count_q != '0);
  assign pop       = valid & ~stall_i & ~redirect_i;
  assign can_issue = (count_q < FULL) | ((count_q == FULL) & pop);

  always_comb begin
    state_d    = state_q;
    req        = 1'b0;
    addr       = fetch_pc_q;
    push       = 1'b0;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      S_IDLE: begin
        req = can_issue & ~redirect_i;
        if (req) begin
          req_addr_d = fetch_pc_q;
          if (imem_ack_i) push = 1'b1;
          else            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        req  = 1'b1;
        addr = req_addr_q;
        if (imem_ack_i) begin
          push    = ~redirect_i;
          state_d = S_IDLE;
        end else if (redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // The memory may not be abandoned mid-request; keep asking for the stale word.
        req  = 1'b1;
        addr = req_addr_q;
        if (imem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (push)       fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_i) fetch_pc_d = redirect_pc_i;
  end

  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]    = addr;
      instr_mem_d[wr_ptr_q] = imem_data_i;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (redirect_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    req_addr_q  <= req_addr_d;
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign imem_req_o     = rst_i & req;
  assign imem_addr_o    = addr;
  assign instr_valid_o  = valid;
  assign instr_o        = valid ? instr_mem_q[rd_ptr_q] : '0;
  assign pc_o           = valid ? pc_mem_q[rd_ptr_q] : '0;
  assign pc_plus_four_o = valid ? (pc_mem_q[rd_ptr_q] + 32'd4) : '0;
  assign count_o        = count_q;

endmodule
